// File: rtl/wshb_mire.sv
// Wishbone master that paints a test pattern into the framebuffer, one 32-bit
// word per pixel in raster order, releasing the bus after every BURST acks.
module wshb_mire #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter int unsigned BURST = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    output logic        frame_done
);

    localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned VW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [VW-1:0]   y_q, y_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [1:0]      pattern_q, pattern_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            frame_done_q, frame_done_d;

    logic            last_x_c;
    logic            last_y_c;
    logic            last_burst_c;

    // RGB colour of pixel (px, py) for a given pattern
    function automatic logic [23:0] pixel(input logic [31:0] px,
                                          input logic [31:0] py,
                                          input logic [1:0]  pat);
        logic [23:0] rgb;
        logic [7:0]  lvl;
        logic [2:0]  bar;
        rgb = 24'h000000;
        lvl = 8'(px & 32'h0000_00FF);
        bar = 3'((px * 32'd8) / 32'(HDISP));
        case (pat)
            2'd0: rgb = (((px & 32'hF) == 32'd0) || ((py & 32'hF) == 32'd0))
                        ? 24'hFFFFFF : 24'h000000;
            2'd1: rgb = {lvl, lvl, lvl};
            2'd2: begin
                case (bar)
                    3'd0:    rgb = 24'hFFFFFF;
                    3'd1:    rgb = 24'hFFFF00;
                    3'd2:    rgb = 24'h00FFFF;
                    3'd3:    rgb = 24'h00FF00;
                    3'd4:    rgb = 24'hFF00FF;
                    3'd5:    rgb = 24'hFF0000;
                    3'd6:    rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            default: rgb = 24'h0000FF;
        endcase
        return rgb;
    endfunction

    assign last_x_c     = (x_q == XW'(HDISP - 1));
    assign last_y_c     = (y_q == VW'(VDISP - 1));
    assign last_burst_c = (burst_cnt_q == BW'(BURST - 1));

    // Next-state, counter and bus-output computation
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        burst_cnt_d  = burst_cnt_q;
        pattern_d    = pattern_q;
        cyc_d        = 1'b0;
        frame_done_d = 1'b0;
        adr_d        = adr_q;
        dat_d        = dat_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = WRITE;
                    x_d       = '0;
                    y_d       = '0;
                    pattern_d = pattern;
                    cyc_d     = 1'b1;
                end
            end
            WRITE: begin
                cyc_d = 1'b1;
                if (wshb_ack) begin
                    if (last_x_c) begin
                        x_d = '0;
                        if (last_y_c) begin
                            y_d          = '0;
                            frame_done_d = 1'b1;
                            pattern_d    = pattern;
                        end else begin
                            y_d = y_q + VW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    burst_cnt_d = last_burst_c ? '0 : burst_cnt_q + BW'(1);
                    // Stopping wins over the burst pause
                    if (!enable) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                        cyc_d       = 1'b0;
                    end else if (last_burst_c) begin
                        state_d = PAUSE;
                        cyc_d   = 1'b0;
                    end
                end
            end
            PAUSE: begin
                if (enable) begin
                    state_d = WRITE;
                    cyc_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stb_d = cyc_d;
        // Address and data only change when the next cycle carries a request
        if (cyc_d) begin
            adr_d = (32'(y_d) * 32'(HDISP) + 32'(x_d)) * 32'd4;
            dat_d = {8'h00, pixel(32'(x_d), 32'(y_d), pattern_d)};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            burst_cnt_q  <= '0;
            pattern_q    <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            burst_cnt_q  <= burst_cnt_d;
            pattern_q    <= pattern_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wshb_cyc    = cyc_q;
    assign wshb_stb    = stb_q;
    assign wshb_we     = 1'b1;
    assign wshb_adr    = adr_q;
    assign wshb_dat_ms = dat_q;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_wshb_mire.sv
// Directed bench for wshb_mire on an 8x4 frame with 4-write bursts.
module tb_wshb_mire;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic [1:0]  pattern;
    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [31:0] wshb_adr;
    logic [31:0] wshb_dat_ms;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_ack;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    wshb_mire #(.HDISP(8), .VDISP(4), .BURST(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .pattern     (pattern),
        .wshb_cyc    (wshb_cyc),
        .wshb_stb    (wshb_stb),
        .wshb_we     (wshb_we),
        .wshb_adr    (wshb_adr),
        .wshb_dat_ms (wshb_dat_ms),
        .wshb_sel    (wshb_sel),
        .wshb_cti    (wshb_cti),
        .wshb_bte    (wshb_bte),
        .wshb_ack    (wshb_ack),
        .frame_done  (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected word for pixel (x, y) on the 8x4 test frame
    function automatic logic [31:0] exp_dat(input int x, input int y, input int pat);
        logic [7:0] g;
        g = 8'(x);
        case (pat)
            0: return (x == 0 || y == 0) ? 32'h00FF_FFFF : 32'h0000_0000;
            1: return {8'h00, g, g, g};
            2: begin
                case (x)
                    0: return 32'h00FF_FFFF;
                    1: return 32'h00FF_FF00;
                    2: return 32'h0000_FFFF;
                    3: return 32'h0000_FF00;
                    4: return 32'h00FF_00FF;
                    5: return 32'h00FF_0000;
                    6: return 32'h0000_00FF;
                    default: return 32'h0000_0000;
                endcase
            end
            default: return 32'h0000_00FF;
        endcase
    endfunction

    // Check one request, hold it for 'waits' cycles, then acknowledge it
    task automatic do_xfer(input int x, input int y, input int pat, input int waits);
        logic [31:0] ea;
        logic [31:0] ed;
        ea = 32'(4 * (y * 8 + x));
        ed = exp_dat(x, y, pat);
        chk("cyc", 32'(wshb_cyc), 32'd1);
        chk("stb", 32'(wshb_stb), 32'd1);
        chk("adr", wshb_adr, ea);
        chk("dat", wshb_dat_ms, ed);
        for (int w = 0; w < waits; w++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk("hold_stb", 32'(wshb_stb), 32'd1);
            chk("hold_adr", wshb_adr, ea);
            chk("hold_dat", wshb_dat_ms, ed);
        end
        wshb_ack = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        wshb_ack = 1'b0;
    endtask

    // Pixels first..first+count-1 of a frame, checking the pause after each 4th ack
    task automatic run_xfers(input int first, input int count, input int pat, input int waits);
        for (int k = first; k < first + count; k++) begin
            do_xfer(k % 8, k / 8, pat, waits);
            if (k % 4 == 3) begin
                chk("pause_cyc", 32'(wshb_cyc), 32'd0);
                chk("pause_stb", 32'(wshb_stb), 32'd0);
                chk("frame_done", 32'(frame_done), (k == 31) ? 32'd1 : 32'd0);
                @(posedge sys_clk);
                @(negedge sys_clk);
                if (k == 31) chk("frame_done_pulse", 32'(frame_done), 32'd0);
            end
        end
    endtask

    initial begin
        sys_rst  = 1'b1;
        enable   = 1'b0;
        pattern  = 2'd0;
        wshb_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_cyc", 32'(wshb_cyc), 32'd0);
        chk("rst_stb", 32'(wshb_stb), 32'd0);
        chk("rst_adr", wshb_adr, 32'd0);
        chk("rst_dat", wshb_dat_ms, 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("we", 32'(wshb_we), 32'd1);
        chk("sel", 32'(wshb_sel), 32'hF);
        chk("cti", 32'(wshb_cti), 32'd0);
        chk("bte", 32'(wshb_bte), 32'd0);

        // Idle with enable low
        sys_rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (c % 5 == 4) begin
                chk("idle_cyc", 32'(wshb_cyc), 32'd0);
                chk("idle_fd", 32'(frame_done), 32'd0);
            end
        end

        // Frame 1: grid, zero wait states
        enable = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        run_xfers(0, 32, 0, 0);

        // Frame 2: grid with 3 wait states; bars selected for the next frame
        pattern = 2'd2;
        run_xfers(0, 32, 0, 3);

        // Frame 3: bars for the whole frame despite a mid-frame change
        run_xfers(0, 10, 2, 0);
        pattern = 2'd1;
        run_xfers(10, 22, 2, 0);

        // Frame 4: gradient, stopped during the write to address 40
        run_xfers(0, 10, 1, 0);
        enable = 1'b0;
        do_xfer(2, 1, 1, 2);
        chk("stop_cyc", 32'(wshb_cyc), 32'd0);
        chk("stop_stb", 32'(wshb_stb), 32'd0);
        repeat (3) @(negedge sys_clk);
        chk("stopped_cyc", 32'(wshb_cyc), 32'd0);

        // Re-enable restarts at address 0
        enable = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        run_xfers(0, 2, 1, 0);

        // Reset while a request is outstanding
        chk("pre_rst_stb", 32'(wshb_stb), 32'd1);
        chk("pre_rst_adr", wshb_adr, 32'd8);
        sys_rst = 1'b1;
        #1;
        chk("async_cyc", 32'(wshb_cyc), 32'd0);
        chk("async_stb", 32'(wshb_stb), 32'd0);
        chk("async_adr", wshb_adr, 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        do_xfer(0, 0, 1, 0);
        do_xfer(1, 0, 1, 1);

        enable = 1'b0;
        repeat (2) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wshb_mire.md
Name: wshb_mire

Overview:
- Wishbone master that writes a test pattern ("mire") into the SDRAM framebuffer, one 32-bit word per pixel, in raster order.
- Sits upstream of the Wishbone interconnect and feeds its mire slave port; the VGA reader shares the same SDRAM through that interconnect.
- Releases the bus periodically so the VGA master is never starved.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BURST, 64, number of acknowledged writes before the block releases cyc for one cycle.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  asynchronous reset, active-high.
- enable  in  1  level; high = keep drawing frames, low = stop at next word boundary.
- pattern  in  2  pattern select, sampled only at frame start.
- wshb_cyc  out  1  Wishbone cycle.
- wshb_stb  out  1  Wishbone strobe.
- wshb_we  out  1  write enable, constant 1.
- wshb_adr  out  32  byte address.
- wshb_dat_ms  out  32  write data.
- wshb_sel  out  4  byte select, constant 4'hF.
- wshb_cti  out  3  constant 3'b000 (classic).
- wshb_bte  out  2  constant 2'b00.
- wshb_ack  in  1  slave acknowledge.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is acked.

Behaviour:
- Reset (async, sys_rst=1) values:
  - state=IDLE, x=0, y=0, burst_cnt=0, pattern_q=0.
  - cyc=0, stb=0, adr=0, dat_ms=0, frame_done=0.
- Counters:
  - x is clog2(HDISP) bits; y is clog2(VDISP) bits; burst_cnt is clog2(BURST) bits.
  - adr = 4*(y*HDISP + x), computed in 32 bits with no truncation.
- Pixel data: dat_ms[31:24]=0; dat_ms[23:0]=RGB by pattern_q:
  - 0: grid. 24'hFFFFFF if x[3:0]==0 or y[3:0]==0, else 24'h000000.
  - 1: horizontal gradient. R=G=B=x[7:0].
  - 2: colour bars. Bar index = x*8/HDISP (integer); colours {white, yellow, cyan, green, magenta, red, blue, black}.
  - 3: solid 24'h0000FF.
- State machine:
  - IDLE:
    - cyc=stb=0.
    - If enable=1: latch pattern_q<=pattern, set x=y=0, go WRITE.
  - WRITE:
    - cyc=stb=1; adr and dat_ms reflect the current x,y.
    - Classic handshake: stb held with adr/dat stable until ack=1. Nothing advances without ack, and wait states are unbounded.
    - On ack:
      - x<=x+1. If x==HDISP-1: x<=0 and y<=y+1.
      - If x==HDISP-1 and y==VDISP-1: y<=0, frame_done<=1 next cycle, pattern_q<=pattern.
      - burst_cnt<=burst_cnt+1.
    - On ack with burst_cnt==BURST-1: burst_cnt<=0, go PAUSE.
    - On ack with enable=0: go IDLE. This takes priority over PAUSE; burst_cnt is cleared.
  - PAUSE:
    - cyc=stb=0 for exactly one cycle.
    - Then WRITE if enable=1, else IDLE.
- Frame wrap does not interrupt the burst; drawing restarts at address 0 seamlessly.
- enable deasserted mid-transfer: the current stb/ack transaction completes; no stb is dropped before ack.
- Simultaneous frame end and burst end: frame_done pulses AND the PAUSE cycle is inserted.
- frame_done is a registered pulse, high for exactly 1 cycle.
- No outputs are combinational from wshb_ack.
- An async reset mid-transfer drops cyc/stb immediately. No transaction is resumed after reset.

Test Plan:
- Reset then idle (sim: HDISP=8, VDISP=4, BURST=4): sys_rst=1, enable=0 -> cyc=stb=0, adr=0, frame_done=0; sys_rst=0 for 20 cycles -> still idle.
- Zero-wait full frame: enable=1, pattern=0, ack=stb every cycle -> 32 writes at adr 0,4,...,124.
  - Data FFFFFF for every word with x=0 or y=0, 000000 elsewhere.
  - cyc low for 1 cycle after each 4th ack.
  - frame_done single pulse after the 32nd ack; next write at adr 0.
- Wait states: ack delayed 3 cycles per transfer -> adr/dat stable while stb=1; write count per frame still 32; no duplicate or skipped address.
- Pattern latch: pattern=2 at frame start, changed to 1 mid-frame -> the entire frame shows colour bars, with x=0 white and x=7 black. The next frame shows the gradient, with dat for x=5 = 24'h050505.
- Stop mid-frame: enable=0 while stb=1 at adr 40, ack 2 cycles later -> the write to 40 completes, then IDLE.
  - Re-enable -> restart at adr 0.
- Reset mid-transfer: sys_rst=1 while stb=1 with no ack -> cyc=stb=0 asynchronously, within the same cycle.
  - After release with enable=1 -> first write at adr 0.
